// File: rtl/pipe_pkg.sv
// Shared defaults and the per-stage update rule used by the pipeline register chain.
package pipe_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        RULE_FLUSH  = 2'd0,
        RULE_HOLD   = 2'd1,
        RULE_BUBBLE = 2'd2,
        RULE_LOAD   = 2'd3
    } stage_rule_e;

    // Flush beats hold; a stage whose upstream neighbour holds takes a bubble.
    function automatic stage_rule_e stage_rule(input logic flush, input logic hold,
                                               input logic hold_up);
        stage_rule_e rule;
        if (flush)        rule = RULE_FLUSH;
        else if (hold)    rule = RULE_HOLD;
        else if (hold_up) rule = RULE_BUBBLE;
        else              rule = RULE_LOAD;
        return rule;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline register stage: WIDTH-bit payload plus valid, with flush/hold/bubble/load select.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = DEF_WIDTH,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush,
    input  logic             hold,
    input  logic             hold_up,
    input  logic [WIDTH-1:0] prev_data,
    input  logic             prev_vld,
    output logic [WIDTH-1:0] data_p,
    output logic             vld_p
);

    stage_rule_e rule;

    assign rule = stage_rule(flush, hold, hold_up);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_p <= BUBBLE;
            vld_p  <= 1'b0;
        end else begin
            case (rule)
                RULE_FLUSH, RULE_BUBBLE: begin
                    data_p <= BUBBLE;
                    vld_p  <= 1'b0;
                end
                RULE_HOLD: begin
                    data_p <= data_p;
                    vld_p  <= vld_p;
                end
                default: begin
                    data_p <= prev_data;
                    vld_p  <= prev_vld;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage pipeline register chain with per-stage stall/flush and saturating event counters.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = DEF_WIDTH,
    parameter int               DEPTH  = DEF_DEPTH,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               CNT_W  = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    input  logic [DEPTH-1:0] stall_i,
    input  logic [DEPTH-1:0] flush_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [DEPTH-1:0] stage_vld_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [DEPTH-1:0] hold;
    logic [DEPTH-1:0] hold_up;
    logic [WIDTH-1:0] data_p [DEPTH];
    logic [DEPTH-1:0] vld_p;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] flush_inc;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // A stall at stage k freezes every stage upstream of it as well.
    always_comb begin
        hold    = '0;
        hold_up = '0;
        hold[DEPTH-1] = stall_i[DEPTH-1];
        for (int k = DEPTH - 2; k >= 0; k--) begin
            hold[k] = stall_i[k] | hold[k+1];
        end
        for (int k = 1; k < DEPTH; k++) begin
            hold_up[k] = hold[k-1];
        end
    end

    always_comb begin
        flush_inc = '0;
        for (int k = 0; k < DEPTH; k++) begin
            flush_inc = flush_inc + CNT_W'(flush_i[k] & vld_p[k]);
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] prev_data;
        logic             prev_vld;
        if (k == 0) begin : g_head
            assign prev_data = data_i;
            assign prev_vld  = valid_i;
        end else begin : g_body
            assign prev_data = data_p[k-1];
            assign prev_vld  = vld_p[k-1];
        end
        pipe_stage #(
            .WIDTH  (WIDTH),
            .BUBBLE (BUBBLE)
        ) u_stage (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .flush     (flush_i[k]),
            .hold      (hold[k]),
            .hold_up   (hold_up[k]),
            .prev_data (prev_data),
            .prev_vld  (prev_vld),
            .data_p    (data_p[k]),
            .vld_p     (vld_p[k])
        );
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (|stall_i) stall_cnt <= sat_add(stall_cnt, CNT_W'(1));
            flush_cnt <= sat_add(flush_cnt, flush_inc);
        end
    end

    assign ready_o     = !hold[0];
    assign data_o      = data_p[DEPTH-1];
    assign valid_o     = vld_p[DEPTH-1];
    assign stage_vld_o = vld_p;
    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain: scoreboard on the output stream plus direct control/counter checks.
module tb_pipe_reg_chain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] data_i;
    logic        valid_i;
    logic [3:0]  stall_i;
    logic [3:0]  flush_i;
    logic        ready_o;
    logic [63:0] data_o;
    logic        valid_o;
    logic [3:0]  stage_vld_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    logic        rst_b_n;
    logic [7:0]  data_b;
    logic        valid_b;
    logic [3:0]  stall_b;
    logic [3:0]  flush_b;
    logic        ready_ob;
    logic [7:0]  data_ob;
    logic        valid_ob;
    logic [3:0]  svld_ob;
    logic [2:0]  scnt_ob;
    logic [2:0]  fcnt_ob;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    pipe_reg_chain #(.WIDTH(64), .DEPTH(4), .CNT_W(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .ready_o     (ready_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .stage_vld_o (stage_vld_o),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
    );

    pipe_reg_chain #(.WIDTH(8), .DEPTH(4), .CNT_W(3)) dut_sat (
        .clk_i       (clk),
        .rst_i       (rst_b_n),
        .data_i      (data_b),
        .valid_i     (valid_b),
        .stall_i     (stall_b),
        .flush_i     (flush_b),
        .ready_o     (ready_ob),
        .data_o      (data_ob),
        .valid_o     (valid_ob),
        .stage_vld_o (svld_ob),
        .stall_cnt_o (scnt_ob),
        .flush_cnt_o (fcnt_ob)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [63:0] v, input bit expect_out);
        data_i  = v;
        valid_i = 1'b1;
        if (expect_out) exp_q.push_back(v);
        step();
    endtask

    task automatic drain(input int n);
        valid_i = 1'b0;
        data_i  = '0;
        repeat (n) step();
    endtask

    // Output monitor: an entry leaves the chain when stage 3 is valid and neither held nor flushed.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && valid_o && !stall_i[3] && !flush_i[3]) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_unexpected: got data_o=%0h, required no output", data_o);
                end else begin
                    check("sb_data", data_o, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        rst_b_n = 1'b0;
        data_i  = '0;
        valid_i = 1'b0;
        stall_i = '0;
        flush_i = '0;
        data_b  = '0;
        valid_b = 1'b0;
        stall_b = '0;
        flush_b = '0;

        step();
        check("rst_valid_o", valid_o, 0);
        check("rst_data_o", data_o, 0);
        check("rst_stage_vld", stage_vld_o, 0);
        check("rst_stall_cnt", stall_cnt_o, 0);
        check("rst_flush_cnt", flush_cnt_o, 0);
        check("rst_ready", ready_o, 1);
        stall_i = 4'b0001;
        #1;
        check("rst_ready_follows_stall", ready_o, 0);
        stall_i = '0;
        rst_n   = 1'b1;
        rst_b_n = 1'b1;

        // Stream 1..8, latency 4
        for (int i = 1; i <= 8; i++) begin
            issue(64'(i), 1'b1);
            if (i <= 4) check("stream_fill_vld", stage_vld_o, 64'((1 << i) - 1));
            if (i == 4) begin
                check("stream_lat_valid", valid_o, 1);
                check("stream_lat_data", data_o, 1);
            end
        end
        drain(4);
        check("stream_empty", stage_vld_o, 0);

        // Stall on stage 2 for two cycles
        issue(64'd11, 1'b1);
        issue(64'd12, 1'b1);
        issue(64'd13, 1'b1);
        data_i  = 64'd14;
        valid_i = 1'b1;
        stall_i = 4'b0100;
        #1;
        check("stall_ready0_a", ready_o, 0);
        step();
        check("stall_bubble_a", valid_o, 0);
        check("stall_hold_vld", stage_vld_o, 4'b0111);
        check("stall_ready0_b", ready_o, 0);
        step();
        check("stall_bubble_b", valid_o, 0);
        check("stall_cnt2", stall_cnt_o, 2);
        stall_i = '0;
        #1;
        check("stall_ready1", ready_o, 1);
        issue(64'd14, 1'b1);
        issue(64'd15, 1'b1);
        issue(64'd16, 1'b1);
        drain(4);

        // Flush stages 0,1 while all four are valid, then repeat on empty stages
        issue(64'd21, 1'b1);
        issue(64'd22, 1'b1);
        issue(64'd23, 1'b1);
        issue(64'd24, 1'b0);
        check("flush_full", stage_vld_o, 4'b1111);
        valid_i = 1'b0;
        flush_i = 4'b0011;
        step();
        check("flush_vld_a", stage_vld_o, 4'b1100);
        check("flush_cnt2", flush_cnt_o, 2);
        step();
        check("flush_vld_b", stage_vld_o, 4'b1000);
        check("flush_cnt_empty", flush_cnt_o, 2);
        flush_i = '0;
        drain(2);
        check("flush_drained", stage_vld_o, 0);

        // Flush and stall on stage 1 together
        issue(64'd31, 1'b1);
        issue(64'd32, 1'b0);
        issue(64'd33, 1'b1);
        data_i  = 64'd34;
        valid_i = 1'b1;
        stall_i = 4'b0010;
        flush_i = 4'b0010;
        #1;
        check("fs_ready0", ready_o, 0);
        step();
        check("fs_vld", stage_vld_o, 4'b1001);
        check("fs_flush_cnt", flush_cnt_o, 3);
        check("fs_stall_cnt", stall_cnt_o, 3);
        stall_i = '0;
        flush_i = '0;
        issue(64'd34, 1'b1);
        drain(4);
        check("fs_drained", stage_vld_o, 0);

        // Asynchronous reset in the middle of a cycle, during a stall
        issue(64'd41, 1'b0);
        issue(64'd42, 1'b0);
        stall_i = 4'b0001;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_vld", stage_vld_o, 0);
        check("arst_data_o", data_o, 0);
        check("arst_stall_cnt", stall_cnt_o, 0);
        check("arst_flush_cnt", flush_cnt_o, 0);
        stall_i = '0;
        valid_i = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        issue(64'd51, 1'b1);
        drain(4);
        check("post_rst_stall_cnt", stall_cnt_o, 0);
        check("post_rst_empty", stage_vld_o, 0);

        // Counter saturation at CNT_W=3, then async clear
        stall_b = 4'b0001;
        repeat (7) step();
        check("sat_cnt7", scnt_ob, 7);
        repeat (3) step();
        check("sat_cnt_hold", scnt_ob, 7);
        check("sat_flush_cnt", fcnt_ob, 0);
        #2;
        rst_b_n = 1'b0;
        #1;
        check("sat_arst_cnt", scnt_ob, 0);
        check("sat_arst_vld", svld_ob, 0);
        stall_b = '0;
        rst_b_n = 1'b1;
        step();

        check("sb_empty", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
